fsm_ns: RTL and testbench

Parametrised N-state FSM kernel: the generalised successor to the team's 2-state kernel. It holds one of NS states and moves on per-pair transition requests `t<x><y>`, flattened into a request matrix. Beyond the binary state it reports:
- a one-hot state,
- a state-entry pulse,
- the previous state,
- a saturating dwell counter.

It sits under control logic as the reusable sequencing core. Surrounding logic decodes its outputs.

---
 rtl/fsm_ns_if.sv | 27 ++
 rtl/fsm_ns.sv | 90 +++++++++
 tb/tb_fsm_ns.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/fsm_ns_if.sv
// fsm_ns_if: groups the request and status signals of the fsm_ns kernel.
//   master modport: the control logic. It drives frz and t and reads the status.
//   slave modport : the fsm_ns kernel. It reads frz and t and drives the status.
//   frz   - freeze; while high, no transition is taken
//   t     - NS*NS request matrix; bit x*NS+y requests the move x -> y
//   st    - binary state         st_oh - one-hot state
//   ent   - state-entry pulse    pst   - state held before the last transition
//   dwell - saturating count of cycles spent in the current state
interface fsm_ns_if #(
    parameter int NS = 4,
    parameter int DW = 8
);
    localparam int SW = (NS > 1) ? $clog2(NS) : 1;

    logic               frz;
    logic [NS*NS-1:0]   t;
    logic [SW-1:0]      st;
    logic [NS-1:0]      st_oh;
    logic               ent;
    logic [SW-1:0]      pst;
    logic [DW-1:0]      dwell;

    modport master (output frz, output t,
                    input  st, input st_oh, input ent, input pst, input dwell);
    modport slave  (input  frz, input t,
                    output st, output st_oh, output ent, output pst, output dwell);
endinterface

// File: rtl/fsm_ns.sv
// fsm_ns: parametrised N-state sequencing kernel. It holds one of NS states and
// moves on per-pair requests taken from the row of the current state. When
// several requests are set in that row, the lowest-index target wins.
//   clk - clock; all updates happen on the rising edge
//   rst - synchronous, active-high reset to RST_ST
//   bus - fsm_ns_if slave: frz, t in; st, st_oh, ent, pst, dwell out
//
// state   | meaning
// --------+------------------------------------------------------------
// 0..NS-1 | legal state; holds, or moves to the lowest requested target
// >= NS   | illegal encoding; recovers to RST_ST on the next edge, ent=1
module fsm_ns #(
    parameter int NS     = 4,
    parameter int RST_ST = 0,
    parameter int DW     = 8
) (
    input  logic   clk,
    input  logic   rst,
    fsm_ns_if.slave bus
);
    localparam int SW = (NS > 1) ? $clog2(NS) : 1;

    logic [SW-1:0] st_q;
    logic [SW-1:0] pst_q;
    logic          ent_q;
    logic [DW-1:0] dwell_q;

    logic [SW-1:0] nxt_d;
    logic          take_d;
    logic          legal;
    logic [NS-1:0] oh;

    assign legal = (32'(st_q) < NS);

    // Scan the row from the top down so that the lowest-index request is
    // written last and wins. The diagonal is skipped.
    always_comb begin
        nxt_d  = '0;
        take_d = 1'b0;
        for (int x = 0; x < NS; x++) begin
            if (st_q == SW'(x)) begin
                for (int y = NS - 1; y >= 0; y--) begin
                    if (y != x && bus.t[x*NS + y]) begin
                        nxt_d  = SW'(y);
                        take_d = 1'b1;
                    end
                end
            end
        end
    end

    // Decoded straight from the state register, so it is all-zero while the
    // encoding is illegal.
    always_comb begin
        oh = '0;
        for (int i = 0; i < NS; i++) begin
            oh[i] = (st_q == SW'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q    <= SW'(RST_ST);
            pst_q   <= SW'(RST_ST);
            ent_q   <= 1'b0;
            dwell_q <= '0;
        end else if (!legal) begin
            st_q    <= SW'(RST_ST);
            pst_q   <= SW'(RST_ST);
            ent_q   <= 1'b1;
            dwell_q <= '0;
        end else if (take_d && !bus.frz) begin
            st_q    <= nxt_d;
            pst_q   <= st_q;
            ent_q   <= 1'b1;
            dwell_q <= '0;
        end else begin
            ent_q <= 1'b0;
            if (dwell_q != {DW{1'b1}}) begin
                dwell_q <= dwell_q + 1'b1;
            end
        end
    end

    assign bus.st    = st_q;
    assign bus.st_oh = oh;
    assign bus.ent   = ent_q;
    assign bus.pst   = pst_q;
    assign bus.dwell = dwell_q;
endmodule

// File: tb/tb_fsm_ns.sv
// tb_fsm_ns: directed plus randomized bench for fsm_ns. It runs two instances:
// NS=4/RST_ST=2/DW=3 and NS=5/RST_ST=4/DW=4. A behavioural model, written from
// the transition rules, predicts every output after each clock edge.
module tb_fsm_ns;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fsm_ns_if #(.NS(4), .DW(3)) if4 ();
    fsm_ns_if #(.NS(5), .DW(4)) if5 ();

    fsm_ns #(.NS(4), .RST_ST(2), .DW(3)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));
    fsm_ns #(.NS(5), .RST_ST(4), .DW(4)) u_dut5 (.clk(clk), .rst(rst), .bus(if5));

    int n_chk  = 0;
    int n_pass = 0;

    // Model state, indexed by instance (0: NS=4, 1: NS=5).
    int m_ns[2]   = '{4, 5};
    int m_rs[2]   = '{2, 4};
    int m_dmax[2] = '{7, 15};
    int m_st[2];
    int m_pst[2];
    int m_ent[2];
    int m_dw[2];

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic model_step(input int k, input bit r, input bit f, input bit [63:0] tv);
        int win;
        if (r) begin
            m_st[k] = m_rs[k]; m_pst[k] = m_rs[k]; m_ent[k] = 0; m_dw[k] = 0;
        end else begin
            win = -1;
            if (!f) begin
                for (int y = 0; y < m_ns[k]; y++)
                    if (win < 0 && y != m_st[k] && tv[m_st[k]*m_ns[k] + y]) win = y;
            end
            if (win >= 0) begin
                m_pst[k] = m_st[k]; m_st[k] = win; m_ent[k] = 1; m_dw[k] = 0;
            end else begin
                m_ent[k] = 0;
                if (m_dw[k] < m_dmax[k]) m_dw[k] = m_dw[k] + 1;
            end
        end
    endtask

    task automatic cycle();
        bit [63:0] t4, t5;
        t4 = 64'(if4.t);
        t5 = 64'(if5.t);
        @(posedge clk);
        model_step(0, rst, if4.frz, t4);
        model_step(1, rst, if5.frz, t5);
        #1;
        chk("st4",    if4.st,    m_st[0]);
        chk("oh4",    if4.st_oh, 1 << m_st[0]);
        chk("pst4",   if4.pst,   m_pst[0]);
        chk("ent4",   if4.ent,   m_ent[0]);
        chk("dwell4", if4.dwell, m_dw[0]);
        chk("st5",    if5.st,    m_st[1]);
        chk("oh5",    if5.st_oh, 1 << m_st[1]);
        chk("pst5",   if5.pst,   m_pst[1]);
        chk("ent5",   if5.ent,   m_ent[1]);
        chk("dwell5", if5.dwell, m_dw[1]);
    endtask

    task automatic req4(input int x, input int y);
        if4.t[x*4 + y] = 1'b1;
    endtask

    initial begin
        if4.frz = 1'b0; if4.t = '0;
        if5.frz = 1'b0; if5.t = '0;

        // Reset for 2 cycles, then hold for 5.
        rst = 1'b1;
        repeat (2) cycle();
        chk("rst_st", if4.st, 2);
        chk("rst_oh", if4.st_oh, 4'b0100);
        chk("rst_ent", if4.ent, 0);
        rst = 1'b0;
        repeat (5) cycle();
        chk("hold_dwell5", if4.dwell, 5);

        // Move 2 -> 0.
        req4(2, 0); cycle(); if4.t = '0;
        chk("to0", if4.st, 0);

        // Priority: row 0 has bits 3, 1 and the diagonal set; target 1 wins.
        req4(0, 3); req4(0, 1); req4(0, 0); cycle(); if4.t = '0;
        chk("prio_st", if4.st, 1);
        chk("prio_pst", if4.pst, 0);
        chk("prio_ent", if4.ent, 1);
        chk("prio_dw", if4.dwell, 0);

        // Row isolation: a request in row 2 does not move state 1.
        req4(2, 3); cycle(); if4.t = '0;
        chk("iso_st", if4.st, 1);
        chk("iso_ent", if4.ent, 0);

        // Chain 1 -> 2 -> 3 on back-to-back cycles.
        req4(1, 2); cycle(); if4.t = '0;
        chk("ch1_st", if4.st, 2);
        chk("ch1_pst", if4.pst, 1);
        req4(2, 3); cycle(); if4.t = '0;
        chk("ch2_st", if4.st, 3);
        chk("ch2_pst", if4.pst, 2);
        chk("ch2_ent", if4.ent, 1);

        // Freeze in state 3 with 3 -> 0 requested, then release.
        if4.frz = 1'b1; req4(3, 0);
        repeat (4) cycle();
        chk("frz_st", if4.st, 3);
        chk("frz_dw", if4.dwell, 4);
        if4.frz = 1'b0; cycle(); if4.t = '0;
        chk("unfrz_st", if4.st, 0);
        chk("unfrz_ent", if4.ent, 1);

        // Saturation of the 3-bit dwell counter, then a transition clears it.
        repeat (12) cycle();
        chk("sat_dw", if4.dwell, 7);
        req4(0, 1); cycle(); if4.t = '0;
        chk("sat_clr", if4.dwell, 0);

        // Reset colliding with a winning request.
        req4(1, 3); rst = 1'b1; cycle(); rst = 1'b0; if4.t = '0;
        chk("col_st", if4.st, 2);
        chk("col_ent", if4.ent, 0);

        // Randomized: sparse requests, occasional freeze, rare reset.
        for (int n = 0; n < 400; n++) begin
            rst     = ($urandom_range(0, 40) == 0);
            if4.frz = ($urandom_range(0, 3) == 0);
            if5.frz = ($urandom_range(0, 3) == 0);
            for (int b = 0; b < 16; b++) if4.t[b] = ($urandom_range(0, 7) == 0);
            for (int b = 0; b < 25; b++) if5.t[b] = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 9) == 0) begin
                if4.t = '0; if5.t = '0;
            end
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
